ffe_ntap: RTL and testbench

FFE_NTAP -- requirements
Module: ffe_ntap

---
 rtl/ffe_ntap.sv | 134 +++++++++++++
 tb/tb_ffe_ntap.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ffe_ntap.sv
// ffe_ntap: N-tap FIR feed-forward equaliser using one shared multiplier, one tap per cycle.
// Define FFE_NTAP_SAT_EN to saturate out-of-range results instead of wrapping them.
module ffe_ntap #(
  parameter int WIDTH  = 12,
  parameter int COEF_W = 12,
  parameter int FRAC   = 6,
  parameter int TAPS   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     in_data,
  input  logic                        coef_we,
  input  logic [$clog2(TAPS)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]    coef_wdata,
  output logic signed [WIDTH-1:0]     out_data,
  output logic                        out_valid
);

  localparam int AW    = $clog2(TAPS);
  localparam int PW    = WIDTH + COEF_W;
  localparam int ACC_W = PW + AW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [AW-1:0]            tap_q, tap_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [WIDTH-1:0]  out_q, out_d;
  logic signed [WIDTH-1:0]  x_q [TAPS];
  logic signed [WIDTH-1:0]  x_d [TAPS];
  logic signed [COEF_W-1:0] h_q [TAPS];
  logic signed [COEF_W-1:0] h_d [TAPS];

  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  macSum;
  logic signed [WIDTH-1:0]  result;
  logic                     addrOk;

  // x_q[0] is the newest sample, so tap k pairs h[k] with x[n-k].
  assign prod     = PW'(x_q[tap_q]) * PW'(h_q[tap_q]);
  assign macSum   = acc_q + ACC_W'(prod);
  assign addrOk   = ({1'b0, coef_addr} < (AW + 1)'(TAPS));
  assign in_ready = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data = out_q;

`ifdef FFE_NTAP_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = macSum >>> FRAC;
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[WIDTH-1:0];
    end else begin
      result = shifted[WIDTH-1:0];
    end
  end
`else
  always_comb begin
    result = WIDTH'(macSum >>> FRAC);
  end
`endif

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    out_d   = out_q;
    x_d     = x_q;
    h_d     = h_q;
    case (state_q)
      IDLE: begin
        // The write lands before the MAC reads it, so a same-cycle sample sees the new tap.
        if (coef_we && addrOk) begin
          h_d[coef_addr] = coef_wdata;
        end
        if (in_valid) begin
          x_d[0] = in_data;
          for (int k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          tap_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = macSum;
        tap_d = tap_q + 1'b1;
        if (tap_q == AW'(TAPS - 1)) begin
          out_d   = result;
          state_d = OUT;
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        h_q[k] <= '0;
      end
      h_q[0] <= COEF_W'(1 << FRAC);
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      x_q     <= x_d;
      h_q     <= h_d;
    end
  end

endmodule

// File: tb/tb_ffe_ntap.sv
// tb_ffe_ntap: randomized self-checking bench for ffe_ntap against an arithmetic FIR model.
// Honours FFE_NTAP_SAT_EN so the same bench covers both output modes.
module tb_ffe_ntap;

  localparam int TAPS = 4;
  localparam int FRAC = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [11:0] coef_wdata;
  logic [11:0] out_data;
  logic        out_valid;

  int passCount  = 0;
  int checkCount = 0;

  int hModel [TAPS];
  int xHist [$];

  ffe_ntap #(
    .WIDTH (12),
    .COEF_W(12),
    .FRAC  (FRAC),
    .TAPS  (TAPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: plain convolution over the received history.
  function automatic void modelReset();
    xHist.delete();
    hModel[0] = 1 << FRAC;
    for (int k = 1; k < TAPS; k++) hModel[k] = 0;
  endfunction

  function automatic void modelAccept(input logic [11:0] d);
    xHist.push_front(int'($signed(d)));
    if (xHist.size() > TAPS) void'(xHist.pop_back());
  endfunction

  function automatic logic [11:0] modelY();
    longint acc = 0;
    longint sh;
    for (int k = 0; k < TAPS; k++) begin
      if (k < xHist.size()) acc += longint'(hModel[k]) * longint'(xHist[k]);
    end
    sh = acc >>> FRAC;
`ifdef FFE_NTAP_SAT_EN
    if (sh > 2047) sh = 2047;
    else if (sh < -2048) sh = -2048;
`endif
    return sh[11:0];
  endfunction

  task automatic doReset();
    rst = 1'b1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    in_data = '0;
    coef_addr = '0;
    coef_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic setCoef(input logic [1:0] a, input logic [11:0] v);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = a;
    coef_wdata = v;
    @(negedge clk);
    coef_we = 1'b0;
    hModel[a] = int'($signed(v));
  endtask

  // mode 0: plain sample; 1: write h[0]=wd during MAC; 2: write h[0]=wd alongside acceptance.
  task automatic runSample(input logic [11:0] d, input int mode, input logic [11:0] wd,
                           output logic [11:0] y, output int lat, output bit readyLow);
    y = 'x;
    lat = -1;
    readyLow = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    if (mode == 2) begin
      coef_we = 1'b1;
      coef_addr = 2'd0;
      coef_wdata = wd;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        in_valid = 1'b0;
        coef_we = (mode == 1);
        coef_addr = 2'd0;
        coef_wdata = wd;
      end
      if (i == 3) coef_we = 1'b0;
      if (in_ready) readyLow = 1'b0;
      if (out_valid) begin
        y = out_data;
        lat = i;
        break;
      end
    end
    coef_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] y;
    int lat;
    bit rl;
    doReset();
    runSample(12'h123, 0, 12'h000, y, lat, rl);
    doReset();
    #1;
    checkCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    else passCount++;
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    else passCount++;
    checkCount++;
    if (out_data !== 12'h000) $display("[TB] FAIL reset_out_data: got %h expected 000", out_data);
    else passCount++;
  endtask

  task automatic test_passthrough();
    logic [11:0] y;
    int lat;
    bit rl;
    doReset();
    runSample(12'h040, 0, 12'h000, y, lat, rl);
    checkCount++;
    if (y !== 12'h040) $display("[TB] FAIL passthrough_data: got %h expected 040", y);
    else passCount++;
    checkCount++;
    if (lat !== TAPS + 1) $display("[TB] FAIL passthrough_latency: got %0d expected %0d", lat, TAPS + 1);
    else passCount++;
    checkCount++;
    if (rl !== 1'b1) $display("[TB] FAIL passthrough_ready_low: got %b expected 1", rl);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL passthrough_ready_after_out: got %b expected 1", in_ready);
    else passCount++;
  endtask

  task automatic test_impulse();
    logic [11:0] coefs [4];
    logic [11:0] expY [4];
    logic [11:0] y;
    int lat;
    bit rl;
    coefs = '{12'h020, 12'hFF0, 12'h00A, 12'hFF6};
    expY  = '{12'h020, 12'hFF0, 12'h00A, 12'hFF6};
    doReset();
    for (int k = 0; k < 4; k++) setCoef(2'(k), coefs[k]);
    for (int n = 0; n < 4; n++) begin
      runSample((n == 0) ? 12'h040 : 12'h000, 0, 12'h000, y, lat, rl);
      checkCount++;
      if (y !== expY[n]) $display("[TB] FAIL impulse_y%0d: got %h expected %h", n, y, expY[n]);
      else passCount++;
    end
  endtask

  task automatic test_overflow();
    logic [11:0] y;
    logic [11:0] expPos;
    logic [11:0] expNeg;
    int lat;
    bit rl;
`ifdef FFE_NTAP_SAT_EN
    expPos = 12'h7FF;
    expNeg = 12'h800;
`else
    expPos = 12'h000;
    expNeg = 12'h000;
`endif
    doReset();
    setCoef(2'd0, 12'h100);
    runSample(12'h400, 0, 12'h000, y, lat, rl);
    checkCount++;
    if (y !== expPos) $display("[TB] FAIL overflow_pos: got %h expected %h", y, expPos);
    else passCount++;
    doReset();
    setCoef(2'd0, 12'h100);
    runSample(12'hC00, 0, 12'h000, y, lat, rl);
    checkCount++;
    if (y !== expNeg) $display("[TB] FAIL overflow_neg: got %h expected %h", y, expNeg);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] expQ [$];
    logic [11:0] e;
    int accCount = 0;
    int outCount = 0;
    int lastAcc = 0;
    bit prevAcc = 1'b0;
    localparam int N = 8;
    doReset();
    for (int k = 0; k < TAPS; k++) setCoef(2'(k), 12'($urandom_range(0, 255)) - 12'd128);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        outCount++;
        e = (expQ.size() > 0) ? expQ.pop_front() : 12'hxxx;
        checkCount++;
        if (out_data !== e) $display("[TB] FAIL b2b_out%0d: got %h expected %h", outCount, out_data, e);
        else passCount++;
      end
      if (cyc == 0) begin
        in_valid = 1'b1;
        in_data = 12'($urandom);
      end
      if (prevAcc) begin
        prevAcc = 1'b0;
        in_data = 12'($urandom);
        if (accCount == N) in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (accCount > 0) begin
          checkCount++;
          if (cyc - lastAcc !== TAPS + 2)
            $display("[TB] FAIL b2b_spacing%0d: got %0d expected %0d", accCount, cyc - lastAcc, TAPS + 2);
          else passCount++;
        end
        modelAccept(in_data);
        expQ.push_back(modelY());
        lastAcc = cyc;
        accCount++;
        prevAcc = 1'b1;
      end
      if (accCount == N && outCount == N && !in_valid) break;
    end
    in_valid = 1'b0;
    checkCount++;
    if (outCount !== N) $display("[TB] FAIL b2b_count: got %0d expected %0d", outCount, N);
    else passCount++;
  endtask

  task automatic test_coef_write_during_mac();
    logic [11:0] y;
    int lat;
    bit rl;
    doReset();
    runSample(12'h040, 1, 12'h000, y, lat, rl);
    checkCount++;
    if (y !== 12'h040) $display("[TB] FAIL macwrite_current: got %h expected 040", y);
    else passCount++;
    runSample(12'h020, 0, 12'h000, y, lat, rl);
    checkCount++;
    if (y !== 12'h020) $display("[TB] FAIL macwrite_next: got %h expected 020", y);
    else passCount++;
    runSample(12'h040, 2, 12'h020, y, lat, rl);
    checkCount++;
    if (y !== 12'h020) $display("[TB] FAIL write_with_accept: got %h expected 020", y);
    else passCount++;
  endtask

  task automatic test_mid_reset();
    logic [11:0] y;
    int lat;
    bit rl;
    bit sawValid = 1'b0;
    doReset();
    setCoef(2'd0, 12'h020);
    setCoef(2'd1, 12'h040);
    runSample(12'h100, 0, 12'h000, y, lat, rl);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 12'h7C0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkCount++;
    if (out_data !== 12'h000) $display("[TB] FAIL midreset_out_data: got %h expected 000", out_data);
    else passCount++;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) sawValid = 1'b1;
      @(negedge clk);
    end
    checkCount++;
    if (sawValid !== 1'b0) $display("[TB] FAIL midreset_no_output: got %b expected 0", sawValid);
    else passCount++;
    runSample(12'h040, 0, 12'h000, y, lat, rl);
    checkCount++;
    if (y !== 12'h040) $display("[TB] FAIL midreset_after: got %h expected 040", y);
    else passCount++;
  endtask

  task automatic test_random();
    logic [11:0] y;
    logic [11:0] e;
    logic [11:0] d;
    logic [11:0] wd;
    int lat;
    int mode;
    bit rl;
    doReset();
    for (int k = 0; k < TAPS; k++) setCoef(2'(k), 12'($urandom));
    for (int n = 0; n < 12; n++) begin
      d = 12'($urandom);
      wd = 12'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 2) hModel[0] = int'($signed(wd));
      modelAccept(d);
      e = modelY();
      runSample(d, mode, wd, y, lat, rl);
      checkCount++;
      if (y !== e) $display("[TB] FAIL random%0d_mode%0d: got %h expected %h", n, mode, y, e);
      else passCount++;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    test_reset();
    test_passthrough();
    test_impulse();
    test_overflow();
    test_back_to_back();
    test_coef_write_during_mac();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
